kf8237_page_address_latch: RTL and testbench

- Downstream companion of the KF8237 DMA controller; builds the full system memory address for each DMA cycle.
- Latches A15:A8, which the controller drives on its data bus during address_strobe.
- Appends the per-channel page (A23:A16) from a CPU-programmable 16-entry page register file.
- Tracks 64 KiB boundary crossings per channel, with an optional page carry.

---
 rtl/kf8237_page_pkg.sv | 36 +++
 rtl/kf8237_page_address_latch_if.sv | 33 +++
 rtl/kf8237_page_register_file.sv | 34 +++
 rtl/kf8237_page_address_latch.sv | 175 +++++++++++++++++
 tb/tb_kf8237_page_address_latch.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/kf8237_page_pkg.sv
// Shared constants and types for the KF8237 page address latch.
// Covers page-file geometry, default channel-to-entry mapping and session state.
package kf8237_page_pkg;

    localparam int unsigned PageDepth     = 16;
    localparam int unsigned PageAddrWidth = 4;
    localparam int unsigned NumChannels   = 4;

    localparam int unsigned Ch0IndexDefault = 7;
    localparam int unsigned Ch1IndexDefault = 3;
    localparam int unsigned Ch2IndexDefault = 1;
    localparam int unsigned Ch3IndexDefault = 2;

    // Status register layout: one sticky boundary flag per channel in the low nibble.
    localparam int unsigned StatusFlagLsb   = 0;
    localparam int unsigned StatusFlagWidth = NumChannels;

    typedef enum logic [0:0] {
        StIdle,
        StActive
    } session_state_e;

    function automatic logic is_one_hot(input logic [NumChannels-1:0] v);
        return (v != '0) && ((v & (v - 4'd1)) == '0);
    endfunction

    function automatic logic [1:0] channel_of(input logic [NumChannels-1:0] v);
        logic [1:0] ch;
        ch = 2'd0;
        for (int i = 0; i < NumChannels; i++) begin
            if (v[i]) ch = 2'(i);
        end
        return ch;
    endfunction

endpackage

// File: rtl/kf8237_page_address_latch_if.sv
// CPU I/O port and DMA controller side-band signals of the page address latch.
interface kf8237_page_address_latch_if #(
    parameter int unsigned PAGE_WIDTH = 8
);
    logic                    chip_select_n;
    logic                    status_select_n;
    logic                    io_read_n;
    logic                    io_write_n;
    logic [3:0]              address_in;
    logic [7:0]              data_bus_in;
    logic [7:0]              data_bus_out;
    logic [7:0]              dma_data_bus;
    logic                    address_strobe;
    logic                    address_enable;
    logic [7:0]              dma_address_low;
    logic [3:0]              dma_acknowledge;
    logic [15+PAGE_WIDTH:0]  memory_address;
    logic                    memory_address_valid;
    logic [3:0]              boundary_flags;

    modport master (
        output chip_select_n, status_select_n, io_read_n, io_write_n, address_in, data_bus_in,
        output dma_data_bus, address_strobe, address_enable, dma_address_low, dma_acknowledge,
        input  data_bus_out, memory_address, memory_address_valid, boundary_flags
    );

    modport slave (
        input  chip_select_n, status_select_n, io_read_n, io_write_n, address_in, data_bus_in,
        input  dma_data_bus, address_strobe, address_enable, dma_address_low, dma_acknowledge,
        output data_bus_out, memory_address, memory_address_valid, boundary_flags
    );

endinterface

// File: rtl/kf8237_page_register_file.sv
// 16-entry page register file: one CPU write port, one CPU read port and one
// channel lookup port used to snapshot the page at session start.
module kf8237_page_register_file
    import kf8237_page_pkg::*;
#(
    parameter int unsigned PAGE_WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     write_enable,
    input  logic [PageAddrWidth-1:0] write_index,
    input  logic [PAGE_WIDTH-1:0]    write_data,
    input  logic [PageAddrWidth-1:0] read_index,
    output logic [PAGE_WIDTH-1:0]    read_data,
    input  logic [PageAddrWidth-1:0] lookup_index,
    output logic [PAGE_WIDTH-1:0]    lookup_data
);

    logic [PAGE_WIDTH-1:0] page_q [PageDepth];

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < PageDepth; i++) begin
                page_q[i] <= '0;
            end
        end else if (write_enable) begin
            page_q[write_index] <= write_data;
        end
    end

    assign read_data   = page_q[read_index];
    assign lookup_data = page_q[lookup_index];

endmodule

// File: rtl/kf8237_page_address_latch.sv
// Builds the 24-bit DMA memory address: latches A15:A8 off the controller data bus,
// prepends the channel page and tracks 64 KiB boundary crossings per channel.
module kf8237_page_address_latch
    import kf8237_page_pkg::*;
#(
    parameter int unsigned PAGE_WIDTH = 8,
    parameter int unsigned CH0_INDEX  = Ch0IndexDefault,
    parameter int unsigned CH1_INDEX  = Ch1IndexDefault,
    parameter int unsigned CH2_INDEX  = Ch2IndexDefault,
    parameter int unsigned CH3_INDEX  = Ch3IndexDefault,
    parameter bit          PAGE_CARRY = 1'b0
) (
    input logic                        clock,
    input logic                        reset_n,
    kf8237_page_address_latch_if.slave bus
);

    localparam int unsigned AddrWidth = 16 + PAGE_WIDTH;
    localparam logic [PAGE_WIDTH-1:0] PageOne = PAGE_WIDTH'(1);

    logic                        io_write_n_q;
    logic                        address_strobe_q;
    logic [NumChannels-1:0]      dack_q;
    session_state_e              state_q, state_d;
    logic [1:0]                  active_channel_q, active_channel_d;
    logic [PAGE_WIDTH-1:0]       active_page_q, active_page_d;
    logic [7:0]                  high_addr_q, high_addr_d;
    logic [7:0]                  prev_high_q, prev_high_d;
    logic                        prev_valid_q, prev_valid_d;
    logic [StatusFlagWidth-1:0]  flags_q, flags_d;
    logic [AddrWidth-1:0]        memory_address_q, memory_address_d;
    logic                        valid_q, valid_d;

    logic                        write_end;
    logic                        dack_one_hot;
    logic [1:0]                  dack_channel;
    logic                        session_start;
    logic                        strobe_fall;
    logic                        wrap_up;
    logic                        wrap_down;
    logic [PageAddrWidth-1:0]    lookup_index;
    logic [PAGE_WIDTH-1:0]       lookup_data;
    logic [PAGE_WIDTH-1:0]       page_read_data;
    logic [7:0]                  data_bus_out;

    // CPU writes commit at the trailing edge of io_write_n.
    assign write_end    = ~io_write_n_q & bus.io_write_n;
    assign dack_one_hot = is_one_hot(bus.dma_acknowledge);
    assign dack_channel = channel_of(bus.dma_acknowledge);
    assign strobe_fall  = address_strobe_q & ~bus.address_strobe & (state_q == StActive);
    assign wrap_up      = (prev_high_q == 8'hFF) && (high_addr_q == 8'h00);
    assign wrap_down    = (prev_high_q == 8'h00) && (high_addr_q == 8'hFF);

    always_comb begin
        lookup_index = PageAddrWidth'(CH0_INDEX);
        unique case (dack_channel)
            2'd0:    lookup_index = PageAddrWidth'(CH0_INDEX);
            2'd1:    lookup_index = PageAddrWidth'(CH1_INDEX);
            2'd2:    lookup_index = PageAddrWidth'(CH2_INDEX);
            2'd3:    lookup_index = PageAddrWidth'(CH3_INDEX);
            default: lookup_index = PageAddrWidth'(CH0_INDEX);
        endcase
    end

    kf8237_page_register_file #(
        .PAGE_WIDTH (PAGE_WIDTH)
    ) u_page_file (
        .clock        (clock),
        .reset_n      (reset_n),
        .write_enable (write_end & ~bus.chip_select_n),
        .write_index  (bus.address_in),
        .write_data   (bus.data_bus_in[PAGE_WIDTH-1:0]),
        .read_index   (bus.address_in),
        .read_data    (page_read_data),
        .lookup_index (lookup_index),
        .lookup_data  (lookup_data)
    );

    // Session FSM: a session opens only when DACK leaves all-zero straight to one-hot.
    always_comb begin
        state_d       = state_q;
        session_start = 1'b0;
        unique case (state_q)
            StIdle: begin
                if ((dack_q == '0) && dack_one_hot) begin
                    state_d       = StActive;
                    session_start = 1'b1;
                end
            end
            StActive: begin
                if (bus.dma_acknowledge == '0) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        high_addr_d      = bus.address_strobe ? bus.dma_data_bus : high_addr_q;
        active_channel_d = active_channel_q;
        active_page_d    = active_page_q;
        prev_high_d      = prev_high_q;
        prev_valid_d     = prev_valid_q;
        flags_d          = flags_q;

        if (write_end && !bus.status_select_n) begin
            flags_d = flags_q & ~bus.data_bus_in[StatusFlagLsb +: StatusFlagWidth];
        end

        if (session_start) begin
            active_channel_d = dack_channel;
            active_page_d    = lookup_data;
            prev_valid_d     = 1'b0;
        end else if (strobe_fall) begin
            // Set is applied after the clear so a simultaneous set wins.
            if (prev_valid_q && (wrap_up || wrap_down)) begin
                flags_d[active_channel_q] = 1'b1;
                if (PAGE_CARRY) begin
                    active_page_d = wrap_up ? active_page_q + PageOne
                                            : active_page_q - PageOne;
                end
            end
            prev_high_d  = high_addr_q;
            prev_valid_d = 1'b1;
        end

        memory_address_d = {active_page_q, high_addr_q, bus.dma_address_low};
        valid_d          = bus.address_enable & dack_one_hot;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            io_write_n_q     <= 1'b1;
            address_strobe_q <= 1'b0;
            dack_q           <= '0;
            state_q          <= StIdle;
            active_channel_q <= 2'd0;
            active_page_q    <= '0;
            high_addr_q      <= 8'h00;
            prev_high_q      <= 8'h00;
            prev_valid_q     <= 1'b0;
            flags_q          <= '0;
            memory_address_q <= '0;
            valid_q          <= 1'b0;
        end else begin
            io_write_n_q     <= bus.io_write_n;
            address_strobe_q <= bus.address_strobe;
            dack_q           <= bus.dma_acknowledge;
            state_q          <= state_d;
            active_channel_q <= active_channel_d;
            active_page_q    <= active_page_d;
            high_addr_q      <= high_addr_d;
            prev_high_q      <= prev_high_d;
            prev_valid_q     <= prev_valid_d;
            flags_q          <= flags_d;
            memory_address_q <= memory_address_d;
            valid_q          <= valid_d;
        end
    end

    // Page file wins over the status register when both are selected.
    always_comb begin
        data_bus_out = 8'h00;
        if (!bus.chip_select_n && !bus.io_read_n) begin
            data_bus_out[PAGE_WIDTH-1:0] = page_read_data;
        end else if (!bus.status_select_n && !bus.io_read_n) begin
            data_bus_out[StatusFlagLsb +: StatusFlagWidth] = flags_q;
        end
    end

    assign bus.data_bus_out         = data_bus_out;
    assign bus.memory_address       = memory_address_q;
    assign bus.memory_address_valid = valid_q;
    assign bus.boundary_flags       = flags_q;

endmodule

// File: tb/tb_kf8237_page_address_latch.sv
// Bench for the page address latch: one instance without and one with page carry,
// sharing stimulus, checked against a cycle-level behavioural model.
module tb_kf8237_page_address_latch;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    kf8237_page_address_latch_if #(.PAGE_WIDTH(8)) bus0 ();
    kf8237_page_address_latch_if #(.PAGE_WIDTH(8)) bus1 ();

    assign bus1.chip_select_n   = bus0.chip_select_n;
    assign bus1.status_select_n = bus0.status_select_n;
    assign bus1.io_read_n       = bus0.io_read_n;
    assign bus1.io_write_n      = bus0.io_write_n;
    assign bus1.address_in      = bus0.address_in;
    assign bus1.data_bus_in     = bus0.data_bus_in;
    assign bus1.dma_data_bus    = bus0.dma_data_bus;
    assign bus1.address_strobe  = bus0.address_strobe;
    assign bus1.address_enable  = bus0.address_enable;
    assign bus1.dma_address_low = bus0.dma_address_low;
    assign bus1.dma_acknowledge = bus0.dma_acknowledge;

    kf8237_page_address_latch #(.PAGE_WIDTH(8), .PAGE_CARRY(1'b0)) dut0 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus0.slave)
    );

    kf8237_page_address_latch #(.PAGE_WIDTH(8), .PAGE_CARRY(1'b1)) dut1 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus1.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int         idx_of [4] = '{7, 3, 1, 2};
    logic [7:0] m_page [16];
    logic [3:0] m_flags;
    logic [7:0] m_high, m_prev_high;
    bit         m_prev_valid, m_sess, m_wr_prev, m_stb_prev, m_valid;
    int         m_ch;
    logic [7:0] m_act [2];
    logic [3:0] m_dack_prev;
    logic [23:0] m_ma [2];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [3:0] dack;
        bit onehot, set_flag;
        dack     = bus0.dma_acknowledge;
        onehot   = ($countones(dack) == 1);
        set_flag = 1'b0;
        if (!reset_n) begin
            foreach (m_page[i]) m_page[i] = 8'h00;
            m_flags = 4'h0; m_high = 8'h00; m_prev_high = 8'h00; m_prev_valid = 1'b0;
            m_ch = 0; m_act[0] = 8'h00; m_act[1] = 8'h00; m_sess = 1'b0;
            m_dack_prev = 4'h0; m_wr_prev = 1'b1; m_stb_prev = 1'b0;
            m_ma[0] = 24'h0; m_ma[1] = 24'h0; m_valid = 1'b0;
            return;
        end
        m_ma[0] = {m_act[0], m_high, bus0.dma_address_low};
        m_ma[1] = {m_act[1], m_high, bus0.dma_address_low};
        m_valid = bus0.address_enable && onehot;
        if (m_sess && m_stb_prev && !bus0.address_strobe) begin
            if (m_prev_valid && m_prev_high == 8'hFF && m_high == 8'h00) begin
                set_flag = 1'b1; m_act[1] = m_act[1] + 8'd1;
            end else if (m_prev_valid && m_prev_high == 8'h00 && m_high == 8'hFF) begin
                set_flag = 1'b1; m_act[1] = m_act[1] - 8'd1;
            end
            m_prev_high  = m_high;
            m_prev_valid = 1'b1;
        end
        if (m_dack_prev == 4'h0 && onehot) begin
            for (int i = 0; i < 4; i++) if (dack[i]) m_ch = i;
            m_act[0] = m_page[idx_of[m_ch]];
            m_act[1] = m_page[idx_of[m_ch]];
            m_prev_valid = 1'b0;
            m_sess = 1'b1;
        end else if (dack == 4'h0) begin
            m_sess = 1'b0;
        end
        if (!m_wr_prev && bus0.io_write_n) begin
            if (!bus0.chip_select_n) m_page[bus0.address_in] = bus0.data_bus_in;
            if (!bus0.status_select_n) m_flags = m_flags & ~bus0.data_bus_in[3:0];
        end
        if (set_flag) m_flags[m_ch] = 1'b1;
        if (bus0.address_strobe) m_high = bus0.dma_data_bus;
        m_dack_prev = dack;
        m_wr_prev   = bus0.io_write_n;
        m_stb_prev  = bus0.address_strobe;
    endtask

    function automatic logic [7:0] model_read();
        if (!bus0.chip_select_n && !bus0.io_read_n) return m_page[bus0.address_in];
        if (!bus0.status_select_n && !bus0.io_read_n) return {4'h0, m_flags};
        return 8'h00;
    endfunction

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        check("model_ma0", bus0.memory_address, m_ma[0]);
        check("model_ma1", bus1.memory_address, m_ma[1]);
        check("model_valid", bus0.memory_address_valid, m_valid);
        check("model_flags", bus1.boundary_flags, m_flags);
        check("model_rd", bus0.data_bus_out, model_read());
    endtask

    task automatic cpu_write(input logic [3:0] idx, input logic [7:0] data,
                             input logic cs_n, input logic ss_n);
        bus0.chip_select_n = cs_n; bus0.status_select_n = ss_n;
        bus0.address_in = idx; bus0.data_bus_in = data;
        bus0.io_write_n = 1'b0;
        tick();
        bus0.io_write_n = 1'b1;
        tick();
        bus0.chip_select_n = 1'b1; bus0.status_select_n = 1'b1;
    endtask

    task automatic cpu_read(input logic [3:0] idx, input logic cs_n, input logic ss_n,
                            input logic rd_n, output logic [7:0] data);
        bus0.chip_select_n = cs_n; bus0.status_select_n = ss_n;
        bus0.address_in = idx; bus0.io_read_n = rd_n;
        #1;
        data = bus0.data_bus_out;
        bus0.chip_select_n = 1'b1; bus0.status_select_n = 1'b1; bus0.io_read_n = 1'b1;
    endtask

    task automatic strobe_pulse(input logic [7:0] high);
        bus0.address_strobe = 1'b1; bus0.dma_data_bus = high;
        tick();
        bus0.address_strobe = 1'b0;
        tick();
    endtask

    typedef struct {
        string      name;
        bit         do_write;
        logic       cs_n;
        logic       ss_n;
        logic       rd_n;
        logic [3:0] idx;
        logic [7:0] data;
        logic [7:0] exp;
    } vec_t;

    initial begin
        logic [7:0] rd;
        vec_t vecs [8];
        vecs[0] = '{"wr_rd_idx0", 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 8'hA5, 8'hA5};
        vecs[1] = '{"wr_rd_idxF", 1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 8'h3C, 8'h3C};
        vecs[2] = '{"rd_unwritten", 1'b0, 1'b0, 1'b1, 1'b0, 4'h1, 8'h00, 8'h00};
        vecs[3] = '{"rd_status", 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00};
        vecs[4] = '{"rd_both_sel", 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 8'hA5};
        vecs[5] = '{"rd_no_sel", 1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 8'h00, 8'h00};
        vecs[6] = '{"wr_both_sel", 1'b1, 1'b0, 1'b0, 1'b0, 4'h2, 8'h0F, 8'h0F};
        vecs[7] = '{"rd_strobe_off", 1'b0, 1'b0, 1'b1, 1'b1, 4'h0, 8'h00, 8'h00};

        reset_n = 1'b0;
        bus0.chip_select_n = 1'b1; bus0.status_select_n = 1'b1;
        bus0.io_read_n = 1'b1; bus0.io_write_n = 1'b1;
        bus0.address_in = 4'h0; bus0.data_bus_in = 8'h00;
        bus0.dma_data_bus = 8'h00; bus0.address_strobe = 1'b0; bus0.address_enable = 1'b0;
        bus0.dma_address_low = 8'h00; bus0.dma_acknowledge = 4'h0;
        tick(); tick();
        check("reset_ma", bus0.memory_address, 24'h0);
        check("reset_valid", bus0.memory_address_valid, 1'b0);
        check("reset_flags", bus0.boundary_flags, 4'h0);
        reset_n = 1'b1;
        tick();

        // Reset / read-back
        cpu_write(4'd7, 8'h12, 1'b0, 1'b1);
        cpu_write(4'd3, 8'h34, 1'b0, 1'b1);
        cpu_read(4'd7, 1'b0, 1'b1, 1'b0, rd); check("rd_idx7", rd, 8'h12);
        cpu_read(4'd3, 1'b0, 1'b1, 1'b0, rd); check("rd_idx3", rd, 8'h34);
        cpu_read(4'd5, 1'b0, 1'b1, 1'b0, rd); check("rd_idx5", rd, 8'h00);
        reset_n = 1'b0; tick(); reset_n = 1'b1;
        cpu_read(4'd7, 1'b0, 1'b1, 1'b0, rd); check("rd_idx7_after_reset", rd, 8'h00);

        // Address build
        cpu_write(4'd7, 8'h0A, 1'b0, 1'b1);
        bus0.dma_acknowledge = 4'b0001; bus0.address_strobe = 1'b1; bus0.dma_data_bus = 8'h5C;
        bus0.address_enable = 1'b1; bus0.dma_address_low = 8'h21;
        tick();
        bus0.address_strobe = 1'b0;
        tick();
        check("build_ma", bus0.memory_address, 24'h0A5C21);
        check("build_valid", bus0.memory_address_valid, 1'b1);
        bus0.dma_acknowledge = 4'h0; bus0.address_enable = 1'b0;
        tick();

        // Page snapshot on channel 1
        cpu_write(4'd3, 8'h55, 1'b0, 1'b1);
        bus0.dma_acknowledge = 4'b0010; bus0.address_enable = 1'b1;
        strobe_pulse(8'h10);
        check("snap_page_before", bus0.memory_address[23:16], 8'h55);
        cpu_write(4'd3, 8'h77, 1'b0, 1'b1);
        tick();
        check("snap_page_held", bus0.memory_address[23:16], 8'h55);
        bus0.dma_acknowledge = 4'h0; tick();
        bus0.dma_acknowledge = 4'b0010; tick(); tick();
        check("snap_page_next", bus0.memory_address[23:16], 8'h77);
        bus0.dma_acknowledge = 4'h0; tick();

        // Upward boundary crossing on channel 2
        cpu_write(4'd1, 8'h40, 1'b0, 1'b1);
        bus0.dma_acknowledge = 4'b0100; tick();
        strobe_pulse(8'hFF);
        strobe_pulse(8'h00);
        tick();
        check("up_flags", bus0.boundary_flags, 4'b0100);
        check("up_page_nocarry", bus0.memory_address[23:16], 8'h40);
        check("up_page_carry", bus1.memory_address[23:16], 8'h41);
        cpu_write(4'd0, 8'h04, 1'b1, 1'b0);
        check("w1c_flags", bus0.boundary_flags, 4'b0000);
        bus0.dma_acknowledge = 4'h0; tick();

        // Downward crossing with page wrap on channel 0
        cpu_write(4'd7, 8'hFF, 1'b0, 1'b1);
        bus0.dma_acknowledge = 4'b0001; tick();
        strobe_pulse(8'h00);
        strobe_pulse(8'hFF);
        tick();
        check("down_page_carry", bus1.memory_address[23:16], 8'hFE);
        check("down_page_nocarry", bus0.memory_address[23:16], 8'hFF);
        check("down_flags", bus1.boundary_flags, 4'b0001);
        bus0.dma_acknowledge = 4'b0011; tick();
        check("multi_dack_valid0", bus0.memory_address_valid, 1'b0);
        check("multi_dack_valid1", bus1.memory_address_valid, 1'b0);

        // Reset mid-session
        bus0.dma_acknowledge = 4'h0; tick();
        bus0.dma_acknowledge = 4'b0001; tick(); tick();
        check("pre_reset_valid", bus0.memory_address_valid, 1'b1);
        reset_n = 1'b0; tick();
        check("midreset_ma", bus1.memory_address, 24'h0);
        check("midreset_valid", bus1.memory_address_valid, 1'b0);
        check("midreset_flags", bus1.boundary_flags, 4'h0);
        reset_n = 1'b1; bus0.dma_acknowledge = 4'h0; bus0.address_enable = 1'b0;
        tick();

        // Table of CPU register accesses
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].do_write) begin
                cpu_write(vecs[i].idx, vecs[i].data, vecs[i].cs_n, vecs[i].ss_n);
                cpu_read(vecs[i].idx, 1'b0, 1'b1, vecs[i].rd_n, rd);
            end else begin
                cpu_read(vecs[i].idx, vecs[i].cs_n, vecs[i].ss_n, vecs[i].rd_n, rd);
            end
            check(vecs[i].name, rd, vecs[i].exp);
        end

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] dack_pick [7];
            logic [7:0] hi_pick [3];
            dack_pick = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3};
            hi_pick   = '{8'h00, 8'hFF, 8'($urandom)};
            reset_n = ($urandom_range(0, 199) != 0);
            bus0.chip_select_n   = $urandom_range(0, 1);
            bus0.status_select_n = $urandom_range(0, 1);
            bus0.io_read_n       = $urandom_range(0, 1);
            bus0.io_write_n      = ($urandom_range(0, 3) != 0);
            bus0.address_in      = 4'($urandom);
            bus0.data_bus_in     = 8'($urandom);
            bus0.dma_data_bus    = hi_pick[$urandom_range(0, 2)];
            bus0.address_strobe  = ($urandom_range(0, 2) == 0);
            bus0.address_enable  = $urandom_range(0, 1);
            bus0.dma_address_low = 8'($urandom);
            if ($urandom_range(0, 9) < 2) bus0.dma_acknowledge = dack_pick[$urandom_range(0, 6)];
            if (!reset_n) begin
                bus0.io_write_n = 1'b1; bus0.dma_acknowledge = 4'h0; bus0.address_strobe = 1'b0;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
